mc_reporter: RTL and testbench
==============================

# mc_reporter

Host-side companion to the Monte Carlo pi engine. On a start pulse it launches one engine run: holds the engine in reset, hands it the point count, then waits for the engine's finish flag. It then snapshots the hit/miss/count results and transmits them as a fixed-format frame on an 8N1 UART line. It sits between the engine instance and the board's serial TX pin.

## Interface
Parameters:
- CLK_DIV, 868: clock cycles per UART bit (100 MHz / 115200); legal range is CLK_DIV ≥ 2.
- RST_CYCLES, 4: cycles the engine reset is held after start; legal range is RST_CYCLES ≥ 2.

Ports:
- clk  in  1  system clock; every register in this block uses this one clock.
- rst  in  1  reset, asynchronous, active-low.
- start  in  1  run request; sampled only in IDLE.
- points_num  in  32  number of points for the run; latched on an accepted start.
- mc_rst  out  1  engine reset (active-high); drives the engine's rst.
- mc_points_num  out  32  latched point count; drives the engine's points_num.
- mc_finish  in  1  engine finish flag; the engine holds it high once finished.
- mc_pi_yes  in  32  engine hit count.
- mc_pi_no  in  32  engine miss count.
- mc_count  in  32  engine total count.
- mc_rng_exhaust  in  1  engine RNG-exhausted flag.
- tx  out  1  UART serial output; idles high.
- busy  out  1  high from an accepted start until the frame completes.
- done  out  1  one-cycle pulse when the last stop bit ends.

## Operation
- Reset values: tx=1, busy=0, done=0, mc_rst=1, mc_points_num=0, state=IDLE, all snapshot registers 0.
- The engine is kept in reset (mc_rst=1) whenever this block is in IDLE.
- **IDLE:**
  - On start=1: latch points_num into mc_points_num, set busy=1, go to ENG_RST.
- **ENG_RST:**
  - Hold mc_rst=1 for RST_CYCLES cycles, then drive mc_rst=0 and go to RUN.
- **RUN:**
  - Wait for mc_finish=1.
  - On the first cycle it is sampled high, capture mc_pi_yes, mc_pi_no, mc_count and mc_rng_exhaust, then go to SEND.
  - There is no timeout; only reset leaves RUN.
- **SEND:** transmit the frame bytes back-to-back with no idle gap between bytes. Frame byte order:
  - 0xA5 header.
  - Flags byte: {7'b0, rng_exhaust}.
  - pi_yes, 4 bytes, MSB first.
  - pi_no, 4 bytes, MSB first.
  - count, 4 bytes, MSB first.
  - Optional checksum byte (see Configuration).
- **Byte format:** 1 start bit (0), then 8 data bits LSB first, then 1 stop bit (1). Each bit lasts exactly CLK_DIV cycles.
- **DONE:** for one cycle set done=1, busy=0 and mc_rst=1, then return to IDLE.
- The snapshot registers are stable for the whole of SEND. Engine outputs changing after capture have no effect on the frame.

## Timing
- An accepted start at edge N gives busy=1 and the new mc_points_num after edge N.
- mc_rst falls after edge N+RST_CYCLES.
- If mc_finish is sampled high at edge M, tx drops for the first start bit after edge M+1.
- Frame length is F×10×CLK_DIV cycles, where F=15 with the checksum and F=14 without it.
- done is high for exactly one cycle, in the cycle after the last stop bit ends; busy falls at that same edge.
- start while busy is ignored and has no effect on the latched count.
- start held high across DONE→IDLE begins a new run on the first IDLE cycle.
- If mc_finish is already high on the first RUN cycle (e.g. points_num=0 with an engine that finishes immediately), the capture happens on that cycle.
- Reset asserted mid-operation takes effect immediately, with no wait for a clock edge:
  - All outputs go to their reset values; tx goes high mid-bit.
  - No done pulse is produced.
- Bit counter width is $clog2(CLK_DIV). The byte index wraps only through DONE, never within a frame.

## Configuration
- MC_REPORTER_CHECKSUM_EN defined:
  - A 15th byte is appended to the frame.
  - Its value is the XOR of frame bytes 1–13 (the flags and payload bytes; the header is excluded).
- MC_REPORTER_CHECKSUM_EN undefined:
  - The frame is 14 bytes.
  - The checksum logic is absent.

## Test plan
- **Reset:** hold rst=0 → tx=1, busy=0, done=0, mc_rst=1, mc_points_num=0. Then release rst → outputs are unchanged until a start arrives.
- **Nominal run** (CLK_DIV=4, checksum enabled):
  - Stimulus: start with points_num=100; model the engine returning pi_yes=0x4E, pi_no=0x16, count=0x64, exhaust=0.
  - Required tx bytes: A5 00 00 00 00 4E 00 00 00 16 00 00 00 64 3C.
  - Required timing: done pulses exactly 600 cycles after the start bit begins.
- **Engine handshake:**
  - mc_points_num=100 and mc_rst stays high for exactly 4 cycles after start.
  - mc_finish asserted 50 cycles later → the capture happens on that edge.
  - Counts changed during SEND → the frame still carries the captured values.
- **Busy guard:** start with points_num=7 during SEND → mc_points_num stays at 100 and exactly one frame and one done pulse are produced.
- **Reset mid-frame:**
  - rst pulsed low during byte 5 → tx=1 immediately and busy=0.
  - A following start gives a complete frame beginning with 0xA5 and containing the new results.
- **Checksum disabled** (macro undefined, exhaust=1): the frame is 14 bytes with flags byte 0x01, and done comes 560 cycles after the start bit.

Source files
------------

// File: rtl/mc_reporter_if.sv
// Engine-side bus between mc_reporter (master) and the Monte Carlo pi engine (slave).
interface mc_reporter_if;
  logic        mc_rst;
  logic [31:0] mc_points_num;
  logic        mc_finish;
  logic [31:0] mc_pi_yes;
  logic [31:0] mc_pi_no;
  logic [31:0] mc_count;
  logic        mc_rng_exhaust;

  modport master (
    output mc_rst, mc_points_num,
    input  mc_finish, mc_pi_yes, mc_pi_no, mc_count, mc_rng_exhaust
  );

  modport slave (
    input  mc_rst, mc_points_num,
    output mc_finish, mc_pi_yes, mc_pi_no, mc_count, mc_rng_exhaust
  );
endinterface

// File: rtl/mc_reporter.sv
// Launches one Monte Carlo engine run, snapshots its results and sends them as an 8N1 UART frame.
// Define MC_REPORTER_CHECKSUM_EN to append an XOR checksum byte (15-byte frame instead of 14).
module mc_reporter #(
  parameter int unsigned CLK_DIV    = 868,
  parameter int unsigned RST_CYCLES = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [31:0]   points_num,
  mc_reporter_if.master eng,
  output logic          tx,
  output logic          busy,
  output logic          done
);

`ifdef MC_REPORTER_CHECKSUM_EN
  localparam int unsigned FRAME_BYTES = 15;
`else
  localparam int unsigned FRAME_BYTES = 14;
`endif

  localparam int unsigned DIV_W = $clog2(CLK_DIV);
  localparam int unsigned RST_W = $clog2(RST_CYCLES);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [RST_W-1:0] RST_LAST = RST_W'(RST_CYCLES - 1);
  localparam logic [3:0]       END_IDX  = 4'(FRAME_BYTES);

  typedef enum logic [2:0] {IDLE, ENG_RST, RUN, SEND, DONE} state_t;

  state_t           state;
  logic [RST_W-1:0] rst_cnt;
  logic [DIV_W-1:0] div_cnt;
  logic [3:0]       bit_idx;
  logic [3:0]       byte_idx;
  logic             mc_rst_q;
  logic [31:0]      points_q;
  logic [31:0]      snap_yes;
  logic [31:0]      snap_no;
  logic [31:0]      snap_count;
  logic             snap_exhaust;
  logic [7:0]       cur_byte;
  logic [2:0]       data_sel;
  logic             tx_bit;

  assign eng.mc_rst        = mc_rst_q;
  assign eng.mc_points_num = points_q;

`ifdef MC_REPORTER_CHECKSUM_EN
  logic [31:0] fold_w;
  logic [7:0]  checksum;

  // XOR of all payload bytes equals the byte-fold of the XOR of the three words.
  always_comb begin
    fold_w   = snap_yes ^ snap_no ^ snap_count;
    checksum = {7'b0, snap_exhaust} ^ fold_w[31:24] ^ fold_w[23:16]
             ^ fold_w[15:8] ^ fold_w[7:0];
  end
`endif

  always_comb begin
    cur_byte = 8'hFF;
    case (byte_idx)
      4'd0:  cur_byte = 8'hA5;
      4'd1:  cur_byte = {7'b0, snap_exhaust};
      4'd2:  cur_byte = snap_yes[31:24];
      4'd3:  cur_byte = snap_yes[23:16];
      4'd4:  cur_byte = snap_yes[15:8];
      4'd5:  cur_byte = snap_yes[7:0];
      4'd6:  cur_byte = snap_no[31:24];
      4'd7:  cur_byte = snap_no[23:16];
      4'd8:  cur_byte = snap_no[15:8];
      4'd9:  cur_byte = snap_no[7:0];
      4'd10: cur_byte = snap_count[31:24];
      4'd11: cur_byte = snap_count[23:16];
      4'd12: cur_byte = snap_count[15:8];
      4'd13: cur_byte = snap_count[7:0];
`ifdef MC_REPORTER_CHECKSUM_EN
      4'd14: cur_byte = checksum;
`endif
      default: cur_byte = 8'hFF;
    endcase
  end

  // bit_idx 0 is the start bit, 1..8 the data bits LSB first, 9 the stop bit.
  always_comb begin
    data_sel = 3'(bit_idx - 4'd1);
    if (bit_idx == 4'd0)
      tx_bit = 1'b0;
    else if (bit_idx == 4'd9)
      tx_bit = 1'b1;
    else
      tx_bit = cur_byte[data_sel];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= IDLE;
      tx           <= 1'b1;
      busy         <= 1'b0;
      done         <= 1'b0;
      mc_rst_q     <= 1'b1;
      points_q     <= '0;
      rst_cnt      <= '0;
      div_cnt      <= '0;
      bit_idx      <= '0;
      byte_idx     <= '0;
      snap_yes     <= '0;
      snap_no      <= '0;
      snap_count   <= '0;
      snap_exhaust <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          mc_rst_q <= 1'b1;
          tx       <= 1'b1;
          if (start) begin
            points_q <= points_num;
            busy     <= 1'b1;
            rst_cnt  <= '0;
            state    <= ENG_RST;
          end
        end
        ENG_RST: begin
          if (rst_cnt == RST_LAST) begin
            mc_rst_q <= 1'b0;
            state    <= RUN;
          end else begin
            rst_cnt <= rst_cnt + RST_W'(1);
          end
        end
        RUN: begin
          if (eng.mc_finish) begin
            snap_yes     <= eng.mc_pi_yes;
            snap_no      <= eng.mc_pi_no;
            snap_count   <= eng.mc_count;
            snap_exhaust <= eng.mc_rng_exhaust;
            div_cnt      <= '0;
            bit_idx      <= '0;
            byte_idx     <= '0;
            state        <= SEND;
          end
        end
        SEND: begin
          // tx is registered, so the frame ends one edge after the last stop-bit cycle is issued.
          if (byte_idx == END_IDX) begin
            tx       <= 1'b1;
            busy     <= 1'b0;
            done     <= 1'b1;
            mc_rst_q <= 1'b1;
            byte_idx <= '0;
            state    <= DONE;
          end else begin
            tx <= tx_bit;
            if (div_cnt == DIV_LAST) begin
              div_cnt <= '0;
              if (bit_idx == 4'd9) begin
                bit_idx  <= '0;
                byte_idx <= byte_idx + 4'd1;
              end else begin
                bit_idx <= bit_idx + 4'd1;
              end
            end else begin
              div_cnt <= div_cnt + DIV_W'(1);
            end
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mc_reporter.sv
// Self-checking bench for mc_reporter: table vectors, random runs and multi-cycle corner sequences.
module tb_mc_reporter;
  localparam int DIV  = 4;
  localparam int RSTC = 4;
`ifdef MC_REPORTER_CHECKSUM_EN
  localparam int NB = 15;
`else
  localparam int NB = 14;
`endif
  localparam int FLEN = NB * 10 * DIV;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [31:0] points_num = '0;
  logic        tx, busy, done;

  mc_reporter_if bus();

  mc_reporter #(.CLK_DIV(DIV), .RST_CYCLES(RSTC)) dut (
    .clk(clk), .rst(rst), .start(start), .points_num(points_num),
    .eng(bus.master), .tx(tx), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int checks = 0;
  int errors = 0;

  logic [7:0] exp_frame [0:14];
  logic [9:0] raw [0:14];

  typedef struct {
    logic [31:0] p, y, n, c;
    logic        e;
    int          dly;
    bit          pre_fin;
    int          guard;
    logic [7:0]  flags;
    logic [7:0]  ck;
  } vec_t;

  vec_t tbl [4];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference frame built straight from the byte-order rules.
  task automatic model(input logic [31:0] y, n, c, input logic e);
    logic [7:0] x;
    exp_frame[0] = 8'hA5;
    exp_frame[1] = {7'b0, e};
    for (int i = 0; i < 4; i++) begin
      exp_frame[2 + i]  = y[8*(3-i) +: 8];
      exp_frame[6 + i]  = n[8*(3-i) +: 8];
      exp_frame[10 + i] = c[8*(3-i) +: 8];
    end
    x = '0;
    for (int i = 1; i < 14; i++) x = x ^ exp_frame[i];
    exp_frame[14] = x;
  endtask

  function automatic logic exp_tx(input int k);
    int b, p;
    logic [7:0] v;
    b = k / (10 * DIV);
    p = (k / DIV) % 10;
    v = exp_frame[b];
    if (p == 0) return 1'b0;
    if (p == 9) return 1'b1;
    return v[p-1];
  endfunction

  task automatic run(input logic [31:0] p, y, n, c, input logic e, input int dly,
                     input bit pre_started, input int guard, input int abort_byte,
                     input bit chain, input logic [31:0] next_p);
    int hi, wave_bad, frame_bad, quiet_bad, b, pp;
    logic [9:0] tmp;
    bit aborted;
    model(y, n, c, e);
    if (pre_started) begin
      @(posedge clk);
      @(negedge clk);
      chk("chain_idle_busy", 32'(busy), 32'd0);
      chk("chain_idle_done", 32'(done), 32'd0);
    end else begin
      @(negedge clk);
      start = 1'b1;
      points_num = p;
    end
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    points_num = $urandom;
    chk("start_busy", 32'(busy), 32'd1);
    chk("start_points", bus.mc_points_num, p);
    hi = 0;
    for (int i = 0; i < RSTC; i++) begin
      if (i > 0) @(negedge clk);
      if (bus.mc_rst === 1'b1) hi++;
    end
    @(negedge clk);
    chk("rst_hold_cycles", 32'(hi), 32'(RSTC));
    chk("rst_release", 32'(bus.mc_rst), 32'd0);
    repeat (dly) @(negedge clk);
    bus.mc_finish = 1'b1;
    bus.mc_pi_yes = y;
    bus.mc_pi_no = n;
    bus.mc_count = c;
    bus.mc_rng_exhaust = e;
    @(posedge clk);
    @(negedge clk);
    bus.mc_pi_yes = $urandom;
    bus.mc_pi_no = $urandom;
    bus.mc_count = $urandom;
    bus.mc_rng_exhaust = ~e;
    chk("tx_idle_after_capture", 32'(tx), 32'd1);
    wave_bad = 0;
    frame_bad = 0;
    aborted = 1'b0;
    for (int k = 0; k < FLEN; k++) begin
      @(negedge clk);
      if (tx !== exp_tx(k)) wave_bad++;
      if (busy !== 1'b1 || done !== 1'b0) frame_bad++;
      if ((k % DIV) == DIV / 2) begin
        b = k / (10 * DIV);
        pp = (k / DIV) % 10;
        tmp = raw[b];
        tmp[pp] = tx;
        raw[b] = tmp;
      end
      if (k == guard) begin
        start = 1'b1;
        points_num = 32'd7;
      end else if (k == guard + 1) begin
        start = 1'b0;
      end
      if (abort_byte >= 0 && k == abort_byte * 10 * DIV + 1) begin
        chk("abort_tx_low_before", 32'(tx), 32'd0);
        rst = 1'b0;
        #1;
        chk("abort_tx", 32'(tx), 32'd1);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        chk("abort_mc_rst", 32'(bus.mc_rst), 32'd1);
        chk("abort_points", bus.mc_points_num, 32'd0);
        aborted = 1'b1;
        break;
      end
    end
    chk("tx_waveform", 32'(wave_bad), 32'd0);
    chk("busy_during_frame", 32'(frame_bad), 32'd0);
    if (aborted) begin
      @(negedge clk);
      chk("abort_done_held", 32'(done), 32'd0);
      rst = 1'b1;
      bus.mc_finish = 1'b0;
      return;
    end
    for (int i = 0; i < NB; i++) begin
      tmp = raw[i];
      chk($sformatf("frame_byte%0d", i), 32'(tmp[8:1]), 32'(exp_frame[i]));
      chk($sformatf("framing%0d", i), 32'({tmp[9], tmp[0]}), 32'd2);
    end
    @(negedge clk);
    chk("done_timing", 32'(done), 32'd1);
    chk("done_busy", 32'(busy), 32'd0);
    chk("done_mc_rst", 32'(bus.mc_rst), 32'd1);
    chk("done_tx", 32'(tx), 32'd1);
    chk("points_kept", bus.mc_points_num, p);
    bus.mc_finish = 1'b0;
    if (chain) begin
      start = 1'b1;
      points_num = next_p;
    end else begin
      quiet_bad = 0;
      for (int i = 0; i < 20; i++) begin
        @(negedge clk);
        if (done !== 1'b0 || busy !== 1'b0 || tx !== 1'b1 || bus.mc_rst !== 1'b1) quiet_bad++;
      end
      chk("single_frame_quiet", 32'(quiet_bad), 32'd0);
    end
  endtask

  initial begin
    logic [31:0] ry, rn, rc, rp;
    int dev;
    tbl[0] = '{32'd100, 32'h4E, 32'h16, 32'h64, 1'b0, 50, 1'b0, 250, 8'h00, 8'h3C};
    tbl[1] = '{32'd0, 32'h0, 32'h0, 32'h0, 1'b1, 0, 1'b1, 100, 8'h01, 8'h01};
    tbl[2] = '{32'hFFFF_FFFF, 32'h1234_5678, 32'h9ABC_DEF0, 32'hFFFF_FFFF, 1'b1, 3, 1'b0, 30, 8'h01, 8'h01};
    tbl[3] = '{32'h0001_0000, 32'hA5A5_A5A5, 32'h5A5A_5A5A, 32'h0000_00FF, 1'b0, 7, 1'b0, 400, 8'h00, 8'hFF};

    bus.mc_finish = 1'b0;
    bus.mc_pi_yes = '0;
    bus.mc_pi_no = '0;
    bus.mc_count = '0;
    bus.mc_rng_exhaust = 1'b0;

    repeat (3) @(negedge clk);
    chk("reset_tx", 32'(tx), 32'd1);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_done", 32'(done), 32'd0);
    chk("reset_mc_rst", 32'(bus.mc_rst), 32'd1);
    chk("reset_points", bus.mc_points_num, 32'd0);
    rst = 1'b1;
    points_num = 32'hDEAD_BEEF;
    dev = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (tx !== 1'b1 || busy !== 1'b0 || done !== 1'b0 || bus.mc_rst !== 1'b1 ||
          bus.mc_points_num !== 32'd0) dev++;
    end
    chk("post_reset_quiet", 32'(dev), 32'd0);

    for (int t = 0; t < 4; t++) begin
      if (tbl[t].pre_fin) begin
        bus.mc_finish = 1'b1;
        bus.mc_pi_yes = tbl[t].y;
        bus.mc_pi_no = tbl[t].n;
        bus.mc_count = tbl[t].c;
        bus.mc_rng_exhaust = tbl[t].e;
      end
      run(tbl[t].p, tbl[t].y, tbl[t].n, tbl[t].c, tbl[t].e, tbl[t].dly, 1'b0,
          tbl[t].guard, -1, 1'b0, 32'd0);
      chk($sformatf("table%0d_flags", t), 32'(raw[1][8:1]), 32'(tbl[t].flags));
`ifdef MC_REPORTER_CHECKSUM_EN
      chk($sformatf("table%0d_cksum", t), 32'(raw[14][8:1]), 32'(tbl[t].ck));
`endif
    end

    // start held high across DONE into IDLE launches the next run at once
    rp = $urandom;
    run(32'd55, 32'h0102_0304, 32'h0A0B_0C0D, 32'h1111_2222, 1'b0, 5, 1'b0, -10, -1, 1'b1, rp);
    run(rp, $urandom, $urandom, $urandom, 1'b1, 2, 1'b1, 300, -1, 1'b0, 32'd0);

    // reset during byte 5, then a fresh full run
    run(32'd900, 32'hCAFE_F00D, 32'h1234_0000, 32'h00FF_00FF, 1'b0, 4, 1'b0, -10, 5, 1'b0, 32'd0);
    run(32'd901, 32'h0BAD_CAFE, 32'h0000_4321, 32'h7777_0001, 1'b1, 1, 1'b0, -10, -1, 1'b0, 32'd0);

    for (int r = 0; r < 4; r++) begin
      ry = $urandom;
      rn = $urandom;
      rc = $urandom;
      rp = $urandom;
      run(rp, ry, rn, rc, 1'($urandom_range(0, 1)), int'($urandom_range(0, 30)), 1'b0,
          int'($urandom_range(0, FLEN - 10)), -1, 1'b0, 32'd0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
